mor1kx_spr_cfg_access: RTL and testbench

- SPR access sequencer sitting directly downstream of the configuration-register block.
- Accepts SPR read/write requests from two requesters: the pipeline control stage and the debug unit.
- Serves group-0 configuration indices 0..10 locally from the static config words.
- Forwards every other SPR address to the unit SPR bus, with an ack handshake and a timeout.
- Returns data plus a one-cycle ack to whichever requester issued the access.

---
 rtl/mor1kx_spr_cfg_access_pkg.sv | 36 +++
 rtl/mor1kx_spr_cfg_mux.sv | 39 +++
 rtl/mor1kx_spr_cfg_access.sv | 172 +++++++++++++++++
 tb/tb_mor1kx_spr_cfg_access.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_spr_cfg_access_pkg.sv
// Shared definitions for the SPR configuration access sequencer:
// SPR address fields, config-word indices and sequencer state encoding.
package mor1kx_spr_cfg_access_pkg;

  localparam int SPR_GROUP_MSB = 15;
  localparam int SPR_GROUP_LSB = 11;
  localparam int SPR_INDEX_MSB = 10;
  localparam int SPR_INDEX_LSB = 0;

  localparam logic [3:0] CFG_IDX_VR       = 4'd0;
  localparam logic [3:0] CFG_IDX_UPR      = 4'd1;
  localparam logic [3:0] CFG_IDX_CPUCFGR  = 4'd2;
  localparam logic [3:0] CFG_IDX_DMMUCFGR = 4'd3;
  localparam logic [3:0] CFG_IDX_IMMUCFGR = 4'd4;
  localparam logic [3:0] CFG_IDX_DCCFGR   = 4'd5;
  localparam logic [3:0] CFG_IDX_ICCFGR   = 4'd6;
  localparam logic [3:0] CFG_IDX_DCFGR    = 4'd7;
  localparam logic [3:0] CFG_IDX_PCCFGR   = 4'd8;
  localparam logic [3:0] CFG_IDX_VR2      = 4'd9;
  localparam logic [3:0] CFG_IDX_AVR      = 4'd10;

  // Wide enough for the largest legal timeout (255).
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } spr_state_e;

  function automatic logic is_local_cfg(input logic [15:0] addr);
    return (addr[SPR_GROUP_MSB:SPR_GROUP_LSB] == '0) &&
           (addr[SPR_INDEX_MSB:SPR_INDEX_LSB] <= 11'(CFG_IDX_AVR));
  endfunction

endpackage

// File: rtl/mor1kx_spr_cfg_mux.sv
// Combinational index-to-word select over the eleven static config words.
// Indices beyond AVR return zero; the caller only uses the result on a local hit.
module mor1kx_spr_cfg_mux
  import mor1kx_spr_cfg_access_pkg::*;
(
  input  logic [3:0]  i_idx,
  input  logic [31:0] i_vr,
  input  logic [31:0] i_upr,
  input  logic [31:0] i_cpucfgr,
  input  logic [31:0] i_dmmucfgr,
  input  logic [31:0] i_immucfgr,
  input  logic [31:0] i_dccfgr,
  input  logic [31:0] i_iccfgr,
  input  logic [31:0] i_dcfgr,
  input  logic [31:0] i_pccfgr,
  input  logic [31:0] i_vr2,
  input  logic [31:0] i_avr,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_idx)
      CFG_IDX_VR:       o_word = i_vr;
      CFG_IDX_UPR:      o_word = i_upr;
      CFG_IDX_CPUCFGR:  o_word = i_cpucfgr;
      CFG_IDX_DMMUCFGR: o_word = i_dmmucfgr;
      CFG_IDX_IMMUCFGR: o_word = i_immucfgr;
      CFG_IDX_DCCFGR:   o_word = i_dccfgr;
      CFG_IDX_ICCFGR:   o_word = i_iccfgr;
      CFG_IDX_DCFGR:    o_word = i_dcfgr;
      CFG_IDX_PCCFGR:   o_word = i_pccfgr;
      CFG_IDX_VR2:      o_word = i_vr2;
      CFG_IDX_AVR:      o_word = i_avr;
      default:          o_word = '0;
    endcase
  end

endmodule

// File: rtl/mor1kx_spr_cfg_access.sv
// SPR access sequencer: serves group-0 config words locally, forwards everything
// else to the unit SPR bus with a timeout, and acks the requester that issued it.
//
//   state   | meaning
//   IDLE    | waiting for a request; pipeline has priority over debug
//   BUS     | strobe on the unit bus, waiting for ack or timeout
//   RESP    | one-cycle ack to the latched requester with rdata/err
module mor1kx_spr_cfg_access
  import mor1kx_spr_cfg_access_pkg::*;
#(
  parameter int    OPTION_SPR_TIMEOUT = 15,
  parameter string FEATURE_DEBUGUNIT  = "NONE"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [15:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic [31:0] cfg_vr_i,
  input  logic [31:0] cfg_upr_i,
  input  logic [31:0] cfg_cpucfgr_i,
  input  logic [31:0] cfg_dmmucfgr_i,
  input  logic [31:0] cfg_immucfgr_i,
  input  logic [31:0] cfg_dccfgr_i,
  input  logic [31:0] cfg_iccfgr_i,
  input  logic [31:0] cfg_dcfgr_i,
  input  logic [31:0] cfg_pccfgr_i,
  input  logic [31:0] cfg_vr2_i,
  input  logic [31:0] cfg_avr_i,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [15:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic DBG_EN = (FEATURE_DEBUGUNIT != "NONE");
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OPTION_SPR_TIMEOUT - 1);

  spr_state_e         r_state;
  spr_state_e         w_state_nxt;
  logic               r_src;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic               r_bus_stb;
  logic               r_bus_we;
  logic [15:0]        r_bus_addr;
  logic [31:0]        r_bus_wdata;
  logic [TIMER_W-1:0] r_timer;

  logic        w_dbg_req;
  logic        w_take_dbg;
  logic        w_req;
  logic        w_we;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_local;
  logic        w_timeout;
  logic [31:0] w_cfg_word;

  assign w_dbg_req  = DBG_EN & dbg_req_i;
  assign w_take_dbg = w_dbg_req & ~cpu_req_i;
  assign w_req      = cpu_req_i | w_dbg_req;
  assign w_we       = w_take_dbg ? dbg_we_i    : cpu_we_i;
  assign w_addr     = w_take_dbg ? dbg_addr_i  : cpu_addr_i;
  assign w_wdata    = w_take_dbg ? dbg_wdata_i : cpu_wdata_i;
  assign w_local    = is_local_cfg(w_addr);
  assign w_timeout  = (r_timer == TIMER_LAST);

  mor1kx_spr_cfg_mux u_cfg_mux (
    .i_idx      (w_addr[3:0]),
    .i_vr       (cfg_vr_i),
    .i_upr      (cfg_upr_i),
    .i_cpucfgr  (cfg_cpucfgr_i),
    .i_dmmucfgr (cfg_dmmucfgr_i),
    .i_immucfgr (cfg_immucfgr_i),
    .i_dccfgr   (cfg_dccfgr_i),
    .i_iccfgr   (cfg_iccfgr_i),
    .i_dcfgr    (cfg_dcfgr_i),
    .i_pccfgr   (cfg_pccfgr_i),
    .i_vr2      (cfg_vr2_i),
    .i_avr      (cfg_avr_i),
    .o_word     (w_cfg_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = w_local ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack_i || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src       <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_bus_stb   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_timer     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_src <= w_take_dbg;
            if (w_local) begin
              // Config words are read-only: writes complete with zero data.
              r_rdata <= w_we ? '0 : w_cfg_word;
              r_err   <= 1'b0;
            end else begin
              r_bus_stb   <= 1'b1;
              r_bus_we    <= w_we;
              r_bus_addr  <= w_addr;
              r_bus_wdata <= w_wdata;
              r_timer     <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack_i) begin
            r_bus_stb <= 1'b0;
            r_rdata   <= r_bus_we ? '0 : bus_rdata_i;
            r_err     <= 1'b0;
          end else if (w_timeout) begin
            r_bus_stb <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: begin
          r_bus_stb <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack_o   = (r_state == ST_RESP) & ~r_src;
  assign dbg_ack_o   = (r_state == ST_RESP) & r_src & DBG_EN;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign bus_stb_o   = r_bus_stb;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_mor1kx_spr_cfg_access.sv
// Table-driven bench with an expected-response queue for the SPR access sequencer,
// plus hand sequences for arbitration, reset during a bus access and the no-debug build.
module tb_mor1kx_spr_cfg_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic        cpu_ack_o, dbg_ack_o, err_o;
  logic [31:0] rdata_o;
  logic        bus_stb_o, bus_we_o, bus_ack_i;
  logic [15:0] bus_addr_o;
  logic [31:0] bus_wdata_o, bus_rdata_i;

  logic        nd_cpu_req = 1'b0;
  logic        nd_cpu_ack, nd_dbg_ack, nd_err, nd_stb, nd_we;
  logic [31:0] nd_rdata, nd_wdata;
  logic [15:0] nd_addr;
  logic        nd_activity = 1'b0;

  localparam logic [31:0] C_VR   = 32'h1200_0001, C_UPR  = 32'h0000_0711,
                          C_CPU  = 32'h0000_0620, C_DMMU = 32'h0000_0A21,
                          C_IMMU = 32'h0000_0B22, C_DC   = 32'h0000_0C23,
                          C_IC   = 32'h0000_0D24, C_DCFG = 32'h0000_0E25,
                          C_PCC  = 32'h0000_0F26, C_VR2  = 32'h0100_0227,
                          C_AVR  = 32'h0102_0328;

  always #5 clk = ~clk;

  mor1kx_spr_cfg_access #(.OPTION_SPR_TIMEOUT(TMO), .FEATURE_DEBUGUNIT("ENABLED")) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack_o),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(dbg_ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .cfg_vr_i(C_VR), .cfg_upr_i(C_UPR), .cfg_cpucfgr_i(C_CPU), .cfg_dmmucfgr_i(C_DMMU),
    .cfg_immucfgr_i(C_IMMU), .cfg_dccfgr_i(C_DC), .cfg_iccfgr_i(C_IC), .cfg_dcfgr_i(C_DCFG),
    .cfg_pccfgr_i(C_PCC), .cfg_vr2_i(C_VR2), .cfg_avr_i(C_AVR),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  // Default build without a debug unit; sees the same debug traffic and must ignore it.
  mor1kx_spr_cfg_access u_nodbg (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(nd_cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(nd_cpu_ack),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(nd_dbg_ack), .rdata_o(nd_rdata), .err_o(nd_err),
    .cfg_vr_i(C_VR), .cfg_upr_i(C_UPR), .cfg_cpucfgr_i(C_CPU), .cfg_dmmucfgr_i(C_DMMU),
    .cfg_immucfgr_i(C_IMMU), .cfg_dccfgr_i(C_DC), .cfg_iccfgr_i(C_IC), .cfg_dcfgr_i(C_DCFG),
    .cfg_pccfgr_i(C_PCC), .cfg_vr2_i(C_VR2), .cfg_avr_i(C_AVR),
    .bus_stb_o(nd_stb), .bus_we_o(nd_we), .bus_addr_o(nd_addr),
    .bus_wdata_o(nd_wdata), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always @(negedge clk)
    if (nd_cpu_ack || nd_dbg_ack || nd_stb || nd_err || (nd_rdata != 32'h0)) nd_activity = 1'b1;

  typedef struct {
    logic        src;      // 0 pipeline, 1 debug
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lat;      // 0 local, n>0 bus ack after n strobe cycles, -1 never
    logic [31:0] brd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;  // ack negedge index after the request edge; equals strobe cycles
  } vec_t;

  typedef struct {
    logic        src;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic src_seen, input int c);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: ack with no expected response at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check32("ack_src", {31'b0, src_seen}, {31'b0, e.src});
      check32("rdata", rdata_o, e.rd);
      check32("err", {31'b0, err_o}, {31'b0, e.err});
      check32("ack_cycle", c, e.cyc);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   stb_n;
    bit   done;
    exp_t e;
    @(negedge clk);
    if (v.src) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    e.src = v.src; e.rd = v.exp_rd; e.err = v.exp_err; e.cyc = v.exp_cyc;
    sb_q.push_back(e);
    stb_n = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'h0;
      if (cpu_ack_o || dbg_ack_o) begin
        check32("dual_ack", {31'b0, cpu_ack_o & dbg_ack_o}, 32'h0);
        check32("stb_low_at_ack", {31'b0, bus_stb_o}, 32'h0);
        check32("stb_cycles", stb_n, v.exp_cyc);
        sb_pop(dbg_ack_o, c);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        done = 1'b1;
      end else if (bus_stb_o) begin
        stb_n++;
        if (stb_n == 1) begin
          check32("bus_addr", {16'h0, bus_addr_o}, {16'h0, v.addr});
          check32("bus_we", {31'b0, bus_we_o}, {31'b0, v.we});
          check32("bus_wdata", bus_wdata_o, v.wdata);
        end
        if (v.lat > 0 && stb_n == v.lat) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = v.brd;
        end
      end else begin
        check32("idle_rdata", rdata_o, 32'h0);
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: no ack for addr 0x%04h at %0t", v.addr, $time);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      sb_q.delete();
    end
  endtask

  initial begin
    int got;
    exp_t e;

    vecs[0]  = '{1'b0, 1'b0, 16'h0002, 32'h0,         0, 32'h0,         C_CPU,         1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0000, 32'hDEADBEEF,  0, 32'h0,         32'h0,         1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 16'h2801, 32'h0,         3, 32'h12345678,  32'h12345678,  1'b0, 3};
    vecs[3]  = '{1'b1, 1'b0, 16'h4000, 32'h0,        -1, 32'h0,         32'h0,         1'b1, TMO};
    vecs[4]  = '{1'b1, 1'b0, 16'h000A, 32'h0,         0, 32'h0,         C_AVR,         1'b0, 0};
    vecs[5]  = '{1'b0, 1'b0, 16'h000B, 32'h0,         1, 32'hA5A55A5A,  32'hA5A55A5A,  1'b0, 1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0800, 32'h0,         2, 32'h0BADF00D,  32'h0BADF00D,  1'b0, 2};
    vecs[7]  = '{1'b0, 1'b1, 16'h1000, 32'h11112222,  1, 32'hFFFFFFFF,  32'h0,         1'b0, 1};
    vecs[8]  = '{1'b0, 1'b0, 16'h0009, 32'h0,         0, 32'h0,         C_VR2,         1'b0, 0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0005, 32'h55AA55AA,  0, 32'h0,         32'h0,         1'b0, 0};
    vecs[10] = '{1'b0, 1'b0, 16'h0001, 32'h0,         0, 32'h0,         C_UPR,         1'b0, 0};
    // Ack on the same edge the timer expires: the ack wins.
    vecs[11] = '{1'b0, 1'b0, 16'hF7FF, 32'h0,       TMO, 32'hCAFEF00D,  32'hCAFEF00D,  1'b0, TMO};
    vecs[12] = '{1'b1, 1'b0, 16'h0006, 32'h0,         0, 32'h0,         C_IC,          1'b0, 0};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

    repeat (2) @(negedge clk);
    check32("rst_acks", {30'b0, cpu_ack_o, dbg_ack_o}, 32'h0);
    check32("rst_rdata", rdata_o, 32'h0);
    check32("rst_err_stb_we", {29'b0, err_o, bus_stb_o, bus_we_o}, 32'h0);
    check32("rst_bus_addr", {16'h0, bus_addr_o}, 32'h0);
    check32("rst_bus_wdata", bus_wdata_o, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Simultaneous requests: pipeline first, one-cycle bubble, then debug.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0008;
    e = '{1'b0, C_UPR, 1'b0, 0}; sb_q.push_back(e);
    e = '{1'b1, C_PCC, 1'b0, 2}; sb_q.push_back(e);
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      @(negedge clk);
      if (cpu_ack_o) begin sb_pop(1'b0, c); cpu_req = 1'b0; got++; end
      if (dbg_ack_o) begin sb_pop(1'b1, c); dbg_req = 1'b0; got++; end
    end
    check32("arb_ack_count", got, 2);
    cpu_req = 1'b0; dbg_req = 1'b0;
    sb_q.delete();

    // Reset while the bus strobe is up: strobe drops at once, no ack follows.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    @(negedge clk);
    check32("mid_stb_high", {31'b0, bus_stb_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check32("rst_async_stb", {31'b0, bus_stb_o}, 32'h0);
    cpu_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check32("rst_no_ack", {30'b0, cpu_ack_o, dbg_ack_o}, 32'h0);
    end
    rst_n = 1'b1;
    run_vec(vecs[0]);

    repeat (2) @(negedge clk);
    check32("nodbg_ignored", {31'b0, nd_activity}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
